// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: next-PC select codes, FSM state
// encodings and the two-word-instruction flag bit locator.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_JMP  = 2'b01;
    localparam logic [1:0] PC_SRC_HOLD = 2'b10;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_IMM  = 2'd2;

    // The MSB of an instruction word marks a trailing immediate word.
    function automatic int has_imm_bit(input int instr_w);
        return instr_w - 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold (en_i low) and flush (valid clear).
// Ports: clk, rst_n, en_i, flush_i, instr/imm/pc in, registered outs.
module if_id_reg #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] imm_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] imm_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] imm_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               valid_q;

    // A flush only drops valid; the payload fields keep their old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                instr_q <= instr_i;
                imm_q   <= imm_i;
                pc_q    <= pc_i;
                valid_q <= 1'b1;
            end
        end
    end

    assign instr_o = instr_q;
    assign imm_o   = imm_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, boot-vector load, two-word assembly, IF/ID.
// Ports: clk, rst_n, pc_src, bubble, jump_target, imem_addr/imem_rdata,
// pc_out, if_id_{instr,imm,pc,valid}.
// Option: FETCH_BOOT_VECTOR_EN adds a BOOT cycle loading PC from
// mem[RESET_PC]; without it fetching starts at RESET_PC directly.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pc_src,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid
);

    localparam int IMM_BIT = has_imm_bit(INSTR_W);

`ifdef FETCH_BOOT_VECTOR_EN
    localparam logic [1:0] ST_RESET = ST_BOOT;
`else
    localparam logic [1:0] ST_RESET = ST_RUN;
`endif

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] held_q, held_d;

    logic               hold;
    logic               jump;
    logic [ADDR_W-1:0]  pc_inc;

    logic               ld_en;
    logic               ld_flush;
    logic [INSTR_W-1:0] ld_instr;
    logic [INSTR_W-1:0] ld_imm;
    logic [ADDR_W-1:0]  ld_pc;

    // Both hold codes and the bubble freeze everything, and win over jump.
    assign hold   = bubble | pc_src[1];
    assign jump   = (pc_src == PC_SRC_JMP) && (state_q != ST_BOOT);
    assign pc_inc = pc_q + 1'b1;

`ifdef FETCH_BOOT_VECTOR_EN
    assign imem_addr = (state_q == ST_BOOT) ? RESET_PC : pc_q;
`else
    assign imem_addr = pc_q;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        held_d   = held_q;
        ld_en    = 1'b0;
        ld_flush = 1'b0;
        ld_instr = imem_rdata;
        ld_imm   = '0;
        ld_pc    = pc_q;
        if (!hold) begin
            if (jump) begin
                // Wrong-path word and any half-built pair are dropped.
                pc_d     = jump_target;
                state_d  = ST_RUN;
                ld_en    = 1'b1;
                ld_flush = 1'b1;
            end else begin
                case (state_q)
`ifdef FETCH_BOOT_VECTOR_EN
                    ST_BOOT: begin
                        pc_d     = ADDR_W'(imem_rdata);
                        state_d  = ST_RUN;
                        ld_en    = 1'b1;
                        ld_flush = 1'b1;
                    end
`endif
                    ST_RUN: begin
                        pc_d  = pc_inc;
                        ld_en = 1'b1;
                        if (imem_rdata[IMM_BIT]) begin
                            held_d   = imem_rdata;
                            state_d  = ST_IMM;
                            ld_flush = 1'b1;
                        end
                    end
                    ST_IMM: begin
                        // PC already moved past the first word.
                        pc_d     = pc_inc;
                        state_d  = ST_RUN;
                        ld_en    = 1'b1;
                        ld_instr = held_q;
                        ld_imm   = imem_rdata;
                        ld_pc    = pc_q - 1'b1;
                    end
                    default: begin
                        state_d = ST_RESET;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            held_q  <= held_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ld_en),
        .flush_i (ld_flush),
        .instr_i (ld_instr),
        .imm_i   (ld_imm),
        .pc_i    (ld_pc),
        .instr_o (if_id_instr),
        .imm_o   (if_id_imm),
        .pc_o    (if_id_pc),
        .valid_o (if_id_valid)
    );

    assign pc_out = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/sequence/two-word/
// jump/hold/wrap/async-reset steps, then randomized traffic vs a model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        bubble;
    logic [15:0] jump_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] pc_out;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic [15:0] if_id_pc;
    logic        if_id_valid;

    logic [15:0] mem [0:65535];

    int checks;
    int errors;

    // Reference state: plain "what has been fetched so far" view.
    bit          m_boot;
    logic [15:0] m_pc;
    bit          m_pend;
    logic [15:0] m_pend_word;
    logic [15:0] m_pend_pc;
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [15:0] m_ipc;
    bit          m_valid;

    fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .bubble      (bubble),
        .jump_target (jump_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .if_id_instr (if_id_instr),
        .if_id_imm   (if_id_imm),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("pc_out", pc_out, m_pc);
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_imm", if_id_imm, m_imm);
        chk("if_id_pc", if_id_pc, m_ipc);
    endtask

    task automatic model_reset();
`ifdef FETCH_BOOT_VECTOR_EN
        m_boot = 1'b1;
`else
        m_boot = 1'b0;
`endif
        m_pc      = 16'h0000;
        m_pend    = 1'b0;
        m_pend_word = 16'h0;
        m_pend_pc = 16'h0;
        m_instr   = 16'h0;
        m_imm     = 16'h0;
        m_ipc     = 16'h0;
        m_valid   = 1'b0;
    endtask

    // One clock: drive, check fetch address, advance model, check outputs.
    task automatic step(input logic [1:0] src, input logic bub,
                        input logic [15:0] tgt);
        logic [15:0] w;
        pc_src      = src;
        bubble      = bub;
        jump_target = tgt;
        #3;
        chk("imem_addr", imem_addr, m_boot ? 16'h0000 : m_pc);
        if (!(bub || src[1])) begin
            if (m_boot) begin
                m_pc   = mem[16'h0000];
                m_boot = 1'b0;
            end else if (src == 2'b01) begin
                m_pc    = tgt;
                m_pend  = 1'b0;
                m_valid = 1'b0;
            end else if (m_pend) begin
                m_instr = m_pend_word;
                m_imm   = mem[m_pc];
                m_ipc   = m_pend_pc;
                m_valid = 1'b1;
                m_pend  = 1'b0;
                m_pc    = m_pc + 16'd1;
            end else begin
                w = mem[m_pc];
                if (w[15]) begin
                    m_pend      = 1'b1;
                    m_pend_word = w;
                    m_pend_pc   = m_pc;
                    m_valid     = 1'b0;
                end else begin
                    m_instr = w;
                    m_imm   = 16'h0;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    // Assert reset away from any edge and confirm it acts immediately.
    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst imem_addr", imem_addr, 16'h0000);
        chk("rst pc_out", pc_out, 16'h0000);
        chk("rst if_id_instr", if_id_instr, 16'h0000);
        chk("rst if_id_imm", if_id_imm, 16'h0000);
        chk("rst if_id_pc", if_id_pc, 16'h0000);
        chk("rst if_id_valid", {15'd0, if_id_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        pc_src      = 2'b00;
        bubble      = 1'b0;
        jump_target = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {1'b0, 15'($urandom)};
        end
        mem[16'h0000] = 16'h0010;
        mem[16'h0020] = 16'h8A01;
        mem[16'h0021] = 16'h1234;
        mem[16'hFFFF] = 16'h0042;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // Boot (when present) then straight-line flow through the pair.
        repeat (40) step(2'b00, 1'b0, 16'h0000);

        // Two-word instruction at 0x20.
        step(2'b01, 1'b0, 16'h0020);
        step(2'b00, 1'b0, 16'h0000);
        chk("pair gap valid", {15'd0, if_id_valid}, 16'h0000);
        step(2'b00, 1'b0, 16'h0000);
        chk("pair instr", if_id_instr, 16'h8A01);
        chk("pair imm", if_id_imm, 16'h1234);
        chk("pair pc", if_id_pc, 16'h0020);
        chk("pair next pc", pc_out, 16'h0022);

        // Jump with flush.
        step(2'b01, 1'b0, 16'h0030);
        step(2'b01, 1'b0, 16'h0100);
        chk("jump flush", {15'd0, if_id_valid}, 16'h0000);
        chk("jump pc", pc_out, 16'h0100);
        step(2'b00, 1'b0, 16'h0000);
        chk("jump target ifid", if_id_pc, 16'h0100);

        // Hold beats jump, for both hold codes and a bubble.
        step(2'b10, 1'b1, 16'h0200);
        step(2'b11, 1'b0, 16'h0200);
        step(2'b01, 1'b1, 16'h0200);
        chk("hold pc", pc_out, 16'h0101);

        // Hold in the middle of a pair keeps the held word.
        step(2'b01, 1'b0, 16'h0020);
        step(2'b00, 1'b0, 16'h0000);
        step(2'b10, 1'b0, 16'h0000);
        step(2'b00, 1'b1, 16'h0000);
        step(2'b00, 1'b0, 16'h0000);

        // PC wrap.
        step(2'b01, 1'b0, 16'hFFFF);
        step(2'b00, 1'b0, 16'h0000);
        chk("wrap pc", pc_out, 16'h0000);
        chk("wrap ifid pc", if_id_pc, 16'hFFFF);

        // Reset mid-pair, then the boot sequence again.
        step(2'b01, 1'b0, 16'h0020);
        step(2'b00, 1'b0, 16'h0000);
        #2;
        async_reset();
        repeat (4) step(2'b00, 1'b0, 16'h0000);

        // Randomized traffic with many pairs, jumps and holds.
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 9) > 2) mem[i][15] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            step(r < 6 ? 2'b00 : r < 8 ? 2'b01 : r == 8 ? 2'b10 : 2'b11,
                 $urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that consumes the hazard unit's `pc_src` and `bubble` decisions. It owns the PC register and the IF/ID pipeline register, and performs the boot-vector load after reset. It assembles two-word (immediate-carrying) instructions before handing them to decode. It sits between instruction memory and the decode stage and is the only writer of PC.

## Interface
- `ADDR_W`, 16: PC / instruction-memory address width (word addressed).
- `INSTR_W`, 16: instruction word width.
- `RESET_PC`, 16'h0000: reset-vector location, or the start PC when the boot vector is compiled out.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pc_src` in 2: from hazard unit. 00 sequential, 01 jump to `jump_target`, 10 hold (load-use), 11 reserved (treated as hold).
- `bubble` in 1: load-use bubble from hazard unit; forces IF/ID hold.
- `jump_target` in ADDR_W: branch/jump target from decode register read.
- `imem_addr` out ADDR_W: combinational read address to instruction memory.
- `imem_rdata` in INSTR_W: asynchronous read data, valid in the same cycle.
- `pc_out` out ADDR_W: current PC.
- `if_id_instr` out INSTR_W: registered instruction word to decode.
- `if_id_imm` out INSTR_W: registered immediate word; 0 for one-word instructions.
- `if_id_pc` out ADDR_W: PC of the first word of `if_id_instr`.
- `if_id_valid` out 1: IF/ID holds a real instruction (0 = NOP/flushed).

## Operation
- FSM states: BOOT, RUN, IMM.
- BOOT:
  - `imem_addr`=RESET_PC.
  - On the next edge, PC<=imem_rdata and state<=RUN.
  - `if_id_valid`=0 throughout.
- RUN: `imem_addr`=PC. Word is two-word when bit [INSTR_W-1]=1 (`HAS_IMM_BIT`).
  - One-word: IF/ID<={word, imm=0, PC, valid=1}; PC<=PC+1.
  - Two-word: latch word into a holding register; PC<=PC+1; state<=IMM; IF/ID valid<=0.
- IMM: `imem_addr`=PC. IF/ID<={held word, imem_rdata, PC-1, valid=1}; PC<=PC+1; state<=RUN.
- `pc_src`=01, any state except BOOT:
  - PC<=jump_target; IF/ID valid<=0 (flush); state<=RUN.
  - Any held partial two-word instruction is discarded.
- `pc_src`=10 or 11, or `bubble`=1:
  - PC, state, holding register and all IF/ID fields hold unchanged.
  - Hold has priority over jump, matching the hazard unit's priority.
- PC arithmetic is modulo 2^ADDR_W: PC=all-ones increments to 0.
- Reset values:
  - PC=RESET_PC; state=BOOT.
  - if_id_instr=0, if_id_imm=0, if_id_pc=0, if_id_valid=0.
- Reset asserted mid-operation: all registers return to reset values immediately, and the boot sequence restarts after release.

## Timing
- Fetch-to-IF/ID latency is 1 cycle for one-word instructions and 2 cycles for two-word instructions.
- Jump penalty: the word fetched in the jump cycle is flushed, and the target word reaches IF/ID on the second edge after `pc_src`=01 is sampled.
- Hold is sampled each cycle with no latency; one cycle of hold equals one repeated IF/ID.
- BOOT lasts exactly 1 cycle after `rst_n` deasserts. The first valid instruction appears on the 2nd edge.

## Configuration
- `FETCH_BOOT_VECTOR_EN`:
  - Defined: BOOT state present; PC is loaded from mem[RESET_PC].
  - Undefined: BOOT removed; reset state is RUN with PC=RESET_PC. The first instruction fetch happens in the first cycle after reset release.

## Structure
- Shared package / `defines.v` holds:
  - `PC_SRC_SEQ`=2'b00, `PC_SRC_JMP`=2'b01, `PC_SRC_HOLD`=2'b10.
  - `HAS_IMM_BIT` index.
  - FSM state encodings (BOOT=2'd0, RUN=2'd1, IMM=2'd2).
- Sub-module `if_id_reg`: IF/ID pipeline register with hold (enable) and flush (valid clear) inputs and asynchronous active-low reset.
- `fetch_unit` keeps the PC, the FSM and the next-PC mux.

## Test plan
- Boot: mem[0]=16'h0010 (ADDR_W=16). After reset release, PC=0x0010 after 1 cycle; the first valid IF/ID has `if_id_pc`=0x0010.
- Sequential flow: mem[0x10..0x12]=one-word ops. `if_id_valid`=1 for 3 consecutive cycles with `if_id_pc`=0x10, 0x11, 0x12 and `if_id_imm`=0.
- Two-word instruction: mem[0x20]=16'h8A01, mem[0x21]=16'h1234. Expect one valid=0 cycle, then instr=8A01, imm=1234, if_id_pc=0x20; next PC=0x22.
- Jump with flush:
  - Stimulus: `pc_src`=01, `jump_target`=0x0100 while PC=0x30.
  - Next cycle: valid=0 and PC=0x0100. Following cycle: `if_id_pc`=0x0100.
- Hold:
  - Stimulus: `pc_src`=10 and `bubble`=1 for 2 cycles, with `jump_target` also driven.
  - PC and IF/ID are unchanged for both cycles; the jump is not taken.
- Wrap and async reset:
  - PC=0xFFFF with a one-word op: next PC is 0x0000.
  - `rst_n` pulsed low mid-IMM: outputs are zero immediately and the FSM re-enters BOOT.
